// File: rtl/tmds_serializer.sv
// tmds_serializer: loads three TMDS channel symbols plus the clock pattern each word period and shifts them out LSB-first.
module tmds_serializer #(
    parameter bit         DDR         = 1'b1,
    parameter logic [9:0] CLK_PATTERN = 10'b0000011111
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pixel_stb,
    input  logic [9:0] ch0,
    input  logic [9:0] ch1,
    input  logic [9:0] ch2,
    output logic [3:0] tmds_d0,
    output logic [3:0] tmds_d1
);
    localparam logic [3:0] LAST = DDR ? 4'd4 : 4'd9;
    localparam int SH = DDR ? 2 : 1;
    logic [3:0] phase_q, phase_d;
    logic [3:0][9:0] sh_q, sh_d;
    logic stb_q, stb_d, load;
    // Phase wraps every word; the last phase loads fresh symbols, all others shift.
    always_comb begin
        load = phase_q == LAST;
        phase_d = load ? 4'd0 : phase_q + 4'd1;
        stb_d = load;
        sh_d[0] = load ? ch0 : sh_q[0] >> SH;
        sh_d[1] = load ? ch1 : sh_q[1] >> SH;
        sh_d[2] = load ? ch2 : sh_q[2] >> SH;
        sh_d[3] = load ? CLK_PATTERN : sh_q[3] >> SH;
    end
    // Reset parks the phase on the load slot so the first edge after release loads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= LAST;
            sh_q <= '0;
            stb_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            sh_q <= sh_d;
            stb_q <= stb_d;
        end
    end
    // Line bits come straight from the low end of each shift register.
    always_comb begin
        tmds_d0 = '0;
        tmds_d1 = '0;
        for (int k = 0; k < 4; k++) begin
            tmds_d0[k] = sh_q[k][0];
            tmds_d1[k] = DDR ? sh_q[k][1] : sh_q[k][0];
        end
    end
    assign pixel_stb = stb_q;
endmodule
